// File: rtl/pio_pkg.sv
// Shared constants for the pio_in_edge input port: register offsets, edge-type
// codes and the request bundle seen on the Avalon-MM slave side.
package pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int PIO_EDGE_RISE = 0;
  localparam int PIO_EDGE_FALL = 1;
  localparam int PIO_EDGE_ANY  = 2;

  typedef struct packed {
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
  } pio_req_t;

  // Picks the edge set a port instance reacts to.
  function automatic logic [31:0] pio_edge_sel(input logic [31:0] rise,
                                               input logic [31:0] fall,
                                               input int          edge_type);
    if (edge_type == PIO_EDGE_RISE)      return rise;
    else if (edge_type == PIO_EDGE_FALL) return fall;
    else                                 return rise | fall;
  endfunction

endpackage

// File: rtl/pio_in_edge_if.sv
// Avalon-MM slave bus plus level interrupt for the pio_in_edge port.
interface pio_in_edge_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write, writedata,
                  output readdata, irq);
endinterface

// File: rtl/pio_debounce.sv
// Single-bit debouncer: cond_o follows sync_i only after sync_i has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_i,
  output logic cond_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          cond_q, cond_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cond_d = cond_q;
    cnt_d  = '0;
    if (sync_i != cond_q) begin
      // Last cycle of the stability window: commit the new level.
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) cond_d = sync_i;
      else                                   cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cond_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cond_q <= cond_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cond_o = cond_q;
endmodule

// File: rtl/pio_in_edge.sv
// Parametrised Avalon-MM input PIO with synchroniser, sticky edge capture and
// masked level irq. Define PIO_DEBOUNCE_EN to add a per-bit debouncer.
module pio_in_edge
  import pio_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  pio_in_edge_if.slave     bus,
  input  logic [WIDTH-1:0] in_port
);
`ifdef PIO_DEBOUNCE_EN
  localparam int ARM_CYC = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
  localparam int ARM_CYC = SYNC_STAGES + 1;
`endif
  localparam int AW = $clog2(ARM_CYC + 1);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      EDGE_TYPE < 0 || EDGE_TYPE > 2 ||
      DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
    $error("pio_in_edge: parameter out of range");
  end

  pio_req_t req;
  assign req = '{address: bus.address, chipselect: bus.chipselect,
                 write: bus.write, writedata: bus.writedata};

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] cond;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [AW-1:0]    arm_q, arm_d;
  logic             armed;
  logic [WIDTH-1:0] rise, fall, edge_hit, clr;
  logic [31:0]      edge_sel;
  logic             wr_mask, wr_edge;
  logic             unused_wdata;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], in_port};

`ifdef PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .sync_i (sync_q[SYNC_STAGES-1][i]),
      .cond_o (cond[i])
    );
  end
`else
  assign cond = sync_q[SYNC_STAGES-1];
`endif

  // Armed once the conditioned path has been flushed with post-reset data.
  assign armed = (arm_q == AW'(ARM_CYC));
  assign rise  = cond & ~prev_q;
  assign fall  = ~cond & prev_q;

  assign wr_mask = req.chipselect & req.write & (req.address == PIO_ADDR_MASK);
  assign wr_edge = req.chipselect & req.write & (req.address == PIO_ADDR_EDGE);

  always_comb begin
    edge_sel = pio_edge_sel(32'(rise), 32'(fall), EDGE_TYPE);
    edge_hit = armed ? edge_sel[WIDTH-1:0] : '0;
    clr      = wr_edge ? req.writedata[WIDTH-1:0] : '0;
    // New edge is OR-ed in after the clear so it wins a same-cycle W1C.
    cap_d    = (cap_q & ~clr) | edge_hit;
    mask_d   = wr_mask ? req.writedata[WIDTH-1:0] : mask_q;
    prev_d   = cond;
    arm_d    = armed ? arm_q : arm_q + AW'(1);
  end

  // DATA returns prev_q, the registered copy of the conditioned input.
  always_comb begin
    rdata_d = '0;
    case (req.address)
      PIO_ADDR_DATA: rdata_d[WIDTH-1:0] = prev_q;
      PIO_ADDR_MASK: rdata_d[WIDTH-1:0] = mask_q;
      PIO_ADDR_EDGE: rdata_d[WIDTH-1:0] = cap_q;
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      arm_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      arm_q   <= arm_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign bus.irq      = |(cap_q & mask_q);
  assign unused_wdata = ^req.writedata;
endmodule

// File: tb/tb_pio_in_edge.sv
// Scoreboard bench for pio_in_edge: a rising-edge and an any-edge instance share
// one stimulus stream; reads push expectations that a monitor pops and checks.
module tb_pio_in_edge;
  localparam int WIDTH = 3;
  localparam int SS    = 2;
  localparam int DC    = 16;
`ifdef PIO_DEBOUNCE_EN
  localparam int DB = DC;
`else
  localparam int DB = 0;
`endif
  localparam int W   = SS + DB;
  localparam int ARM = SS + 1 + DB;

  typedef struct {
    string       nm;
    logic [31:0] e0;
    logic [31:0] e2;
    logic        i0;
    logic        i2;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write = 1'b0;
  logic [31:0]      writedata = '0;
  logic [WIDTH-1:0] in_port = '1;
  bit               rd_strobe = 1'b0;
  bit               mon_vld = 1'b0;
  int               checks = 0;
  int               errors = 0;
  exp_t             sbq[$];
  exp_t             mon_e;

  always #5 clk = ~clk;

  pio_in_edge_if bus0();
  pio_in_edge_if bus2();

  assign bus0.address = address;  assign bus2.address = address;
  assign bus0.chipselect = chipselect;  assign bus2.chipselect = chipselect;
  assign bus0.write = write;  assign bus2.write = write;
  assign bus0.writedata = writedata;  assign bus2.writedata = writedata;

  pio_in_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DC)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .in_port(in_port));
  pio_in_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DC)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .in_port(in_port));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: readdata is valid the cycle after a read was presented.
  always @(posedge clk) mon_vld <= rd_strobe;
  always @(negedge clk) begin
    if (mon_vld) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: got empty queue expected an entry");
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.nm, "/rd0"},  bus0.readdata, mon_e.e0);
        chk({mon_e.nm, "/rd2"},  bus2.readdata, mon_e.e2);
        chk({mon_e.nm, "/irq0"}, {31'b0, bus0.irq}, {31'b0, mon_e.i0});
        chk({mon_e.nm, "/irq2"}, {31'b0, bus2.irq}, {31'b0, mon_e.i2});
      end
    end
  end

  task automatic step(input logic [1:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                      input logic [31:0] e0, input logic [31:0] e2, input bit i0, input bit i2,
                      input string nm);
    exp_t e;
    @(negedge clk);
    address = a; chipselect = wr; write = wr; writedata = wd; rd_strobe = rd;
    if (rd) begin
      e.nm = nm; e.e0 = e0; e.e2 = e2; e.i0 = i0; e.i2 = i2;
      sbq.push_back(e);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e0, input logic [31:0] e2,
                    input bit i0, input bit i2, input string nm);
    step(a, 1'b1, 1'b0, 32'h0, e0, e2, i0, i2, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    step(a, 1'b0, 1'b1, wd, 32'h0, 32'h0, 1'b0, 1'b0, "");
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Input held high through reset must not look like a rising edge.
    idle(2);
    rd(2'd0, 0, 0, 0, 0, "rst_data");
    reset = 1'b0;
    idle(ARM + 4);
    rd(2'd0, 7, 7, 0, 0, "arm_data");
    rd(2'd3, 0, 0, 0, 0, "arm_edge");

    in_port = 3'b000;
    idle(W + 3);
    rd(2'd3, 0, 7, 0, 0, "fall_cap");
    rd(2'd0, 0, 0, 0, 0, "fall_data0");
    wr(2'd3, 32'h7);
    rd(2'd3, 0, 0, 0, 0, "clr_all");
    wr(2'd2, 32'h1);
    rd(2'd2, 1, 1, 0, 0, "mask_rd");

    // Rising edge on bit0: irq with the capture, EDGE_CAP readable a cycle later.
    in_port = 3'b001;
    for (int i = 1; i <= W + 1; i++)
      rd(2'd3, (i > W) ? 1 : 0, (i > W) ? 1 : 0, i >= W, i >= W, $sformatf("rise_lat%0d", i));
    wr(2'd3, 32'h1);
    rd(2'd3, 0, 0, 0, 0, "clr_irq");

    in_port = 3'b000;
    for (int i = 1; i <= W + 1; i++)
      rd(2'd0, (i > W) ? 0 : 1, (i > W) ? 0 : 1, 0, i >= W, $sformatf("fall_data%0d", i));
    rd(2'd3, 0, 1, 0, 1, "fall_only");
    wr(2'd3, 32'h1);

    // Clear lands on the same edge that captures: capture wins.
    in_port = 3'b001;
    idle(W - 1);
    wr(2'd3, 32'h1);
    rd(2'd3, 1, 1, 1, 1, "clr_vs_edge");

    wr(2'd3, 32'h7);
    wr(2'd2, 32'h0);
    in_port = 3'b101;
    idle(W + 2);
    in_port = 3'b001;
    idle(W + 2);
    rd(2'd3, 4, 4, 0, 0, "any_cap");
    wr(2'd2, 32'h4);
    rd(2'd2, 4, 4, 1, 1, "mask_irq");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 0, 0, 1, 1, "rsvd");
    wr(2'd2, 32'hFFFF_FFFD);
    rd(2'd2, 5, 5, 1, 1, "mask_width");

`ifdef PIO_DEBOUNCE_EN
    wr(2'd3, 32'h7);
    in_port = 3'b011;
    idle(10);
    in_port = 3'b001;
    idle(W + 4);
    rd(2'd0, 1, 1, 0, 0, "glitch_data");
    rd(2'd3, 0, 0, 0, 0, "glitch_edge");
`endif

    in_port = 3'b000;
    idle(W + 3);
    wr(2'd3, 32'h7);
    wr(2'd2, 32'h7);
    in_port = 3'b101;
    idle(W + 3);
    rd(2'd3, 5, 5, 1, 1, "pre_rst");
    idle(1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_now/rd0", bus0.readdata, 32'h0);
    chk("rst_now/rd2", bus2.readdata, 32'h0);
    chk("rst_now/irq0", {31'b0, bus0.irq}, 32'h0);
    chk("rst_now/irq2", {31'b0, bus2.irq}, 32'h0);
    rd(2'd3, 0, 0, 0, 0, "rst_edge");
    in_port = 3'b111;
    idle(2);
    reset = 1'b0;
    idle(ARM + 4);
    rd(2'd3, 0, 0, 0, 0, "no_cap_rearm");
    rd(2'd2, 0, 0, 0, 0, "mask_rst");
    rd(2'd0, 7, 7, 0, 0, "rearm_data");
    in_port = 3'b000;
    idle(W + 3);
    rd(2'd3, 0, 7, 0, 0, "rearm_fall");

    idle(3);
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pio_in_edge.md
# pio_in_edge

Parametrised Avalon-MM input PIO slave: successor to the fixed 3-bit read-only input port, sitting on the Qsys system interconnect between external sensor pins and the Nios II data master. Synchronises a WIDTH-bit input bus, optionally debounces it, and detects edges into a sticky capture register. Generates a level interrupt from the captured edges gated by a software mask.

## Interface
- WIDTH, 3: input bus width, legal 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, legal 2..4.
- EDGE_TYPE, 0: 0 rising, 1 falling, 2 any edge.
- DEBOUNCE_CYCLES, 16: stable cycles required before a debounced bit changes, legal 2..65535; used only with PIO_DEBOUNCE_EN.
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word register offset.
- chipselect  in  1  slave select.
- write  in  1  write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data, bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map:
  - Offset 0 DATA (RO): conditioned input value.
  - Offset 1: reserved, reads 0, writes ignored.
  - Offset 2 IRQ_MASK (RW): WIDTH bits.
  - Offset 3 EDGE_CAP (R/W1C): WIDTH sticky bits.
- Datapath per bit: in_port, SYNC_STAGES-flop synchroniser (sync_q), optional debouncer (cond_q), then edge detector comparing cond_q against prev_q.
- Edge detect:
  - rise = cond_q & ~prev_q.
  - fall = ~cond_q & prev_q.
  - EDGE_TYPE selects rise, fall or rise|fall.
  - A detected edge sets EDGE_CAP[i].
- Arming: after reset deassertion, detection is suppressed until the conditioned path is valid. The arm counter counts SYNC_STAGES+1 cycles (plus DEBOUNCE_CYCLES when debounce is compiled in). While unarmed, prev_q tracks cond_q and no capture occurs. This means an input held high through reset does not raise a rising edge.
- EDGE_CAP write: chipselect & write & address==3 clears each bit where writedata[i]=1.
- Simultaneous clear and new edge on the same bit in the same cycle: edge wins, bit stays 1.
- IRQ_MASK write: chipselect & write & address==2 loads writedata[WIDTH-1:0].
- irq = |(EDGE_CAP & IRQ_MASK), driven directly from registers with no extra flop.
- Read: readdata is loaded every clock from the address mux (chipselect ignored on read, consistent with the existing PIO). Reserved offset returns 0.
- Reset values:
  - readdata 0, IRQ_MASK 0, EDGE_CAP 0, irq 0.
  - Synchroniser and prev_q 0; debouncer state 0, counters 0.
  - Arm counter 0 (unarmed).

## Timing
- Read latency is 1 cycle: address presented at edge N, value valid on readdata after edge N+1.
- Without debounce, an in_port change stable before edge N:
  - appears in sync_q after edge N+SYNC_STAGES-1;
  - is visible on DATA readdata at edge N+SYNC_STAGES+1 with address held at 0;
  - sets EDGE_CAP at edge N+SYNC_STAGES;
  - asserts irq (if masked in) in the same cycle that EDGE_CAP is set.
- Debounce adds exactly DEBOUNCE_CYCLES cycles after sync_q settles.
- A write at edge N takes effect at edge N. A read of the same register issued at edge N+1 returns the new value.
- Reset asserted mid-operation clears everything on the next edge and re-enters the unarmed state.

## Configuration
- PIO_DEBOUNCE_EN defined:
  - Each bit has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets whenever sync_q equals cond_q.
  - cond_q toggles when the counter reaches DEBOUNCE_CYCLES-1 with sync_q still different, and the counter returns to 0.
  - Glitches shorter than DEBOUNCE_CYCLES never reach DATA or EDGE_CAP.
- PIO_DEBOUNCE_EN undefined: cond_q = sync_q, no counters are synthesised, and DEBOUNCE_CYCLES is ignored.

## Structure
- Shared package pio_pkg holds:
  - register offsets: PIO_ADDR_DATA=0, PIO_ADDR_MASK=2, PIO_ADDR_EDGE=3;
  - edge type constants: PIO_EDGE_RISE=0, PIO_EDGE_FALL=1, PIO_EDGE_ANY=2.
- Sub-module pio_debounce holds the single-bit debouncer (parameter DEBOUNCE_CYCLES). It is instantiated WIDTH times in a generate loop under PIO_DEBOUNCE_EN.
- The synchroniser, edge detector and register file stay in the top level.

## Test plan
- Reset then idle with in_port=3'b111 held through reset: DATA reads 0x7 after arming, EDGE_CAP reads 0, irq stays 0.
- EDGE_TYPE=0, IRQ_MASK=0x1, in_port[0] 0→1: EDGE_CAP=0x1 at SYNC_STAGES cycles after the change, irq=1, and a 1→0 transition adds nothing.
- Write 0x1 to offset 3: EDGE_CAP returns 0, irq drops the next cycle. Repeat the clear coinciding with a new rising edge: EDGE_CAP stays 0x1.
- EDGE_TYPE=2, in_port[2] toggles twice, IRQ_MASK=0: EDGE_CAP=0x4, irq=0; then write IRQ_MASK=0x4: irq=1.
- PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - 10-cycle pulse on in_port[1]: DATA and EDGE_CAP unchanged.
  - 20-cycle high level: DATA[1]=1 exactly 16 cycles after sync_q rises.
- Assert reset while EDGE_CAP=0x5 and IRQ_MASK=0x7: on the next edge readdata, EDGE_CAP, IRQ_MASK and irq are 0, and no capture occurs until re-armed.
